// File: rtl/spmv_pkg.sv
// Shared types and constants for the SpMV row-accumulation controller.
package spmv_pkg;

   localparam int              FP16_W    = 16;
   localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACC   = 3'd1,
      DRAIN = 3'd2,
      OUT   = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/spmv_row_accum_ctrl_if.sv
// Product stream, adder operand/result and row-result bus of spmv_row_accum_ctrl.
// y_nnz exists only when SPMV_ROW_NNZ_CNT_EN is defined.
interface spmv_row_accum_ctrl_if #(
   parameter int ROW_W = 8
);
   import spmv_pkg::*;

   logic              p_valid;
   logic              p_ready;
   logic [FP16_W-1:0] p_data;
   logic              p_last;
   logic              p_empty;

   logic [FP16_W-1:0] add_a;
   logic [FP16_W-1:0] add_b;
   logic [FP16_W-1:0] add_result;

   logic              y_valid;
   logic              y_ready;
   logic [FP16_W-1:0] y_data;
   logic [ROW_W-1:0]  y_row;
`ifdef SPMV_ROW_NNZ_CNT_EN
   logic [ROW_W-1:0]  y_nnz;
`endif

   // Driven by the product source, the adder and the result consumer.
   modport master (
      output p_valid, p_data, p_last, p_empty, add_result, y_ready,
      input  p_ready, add_a, add_b, y_valid, y_data, y_row
`ifdef SPMV_ROW_NNZ_CNT_EN
      , input y_nnz
`endif
   );

   // The controller side.
   modport slave (
      input  p_valid, p_data, p_last, p_empty, add_result, y_ready,
      output p_ready, add_a, add_b, y_valid, y_data, y_row
`ifdef SPMV_ROW_NNZ_CNT_EN
      , output y_nnz
`endif
   );

endinterface

// File: rtl/spmv_row_accum_ctrl.sv
// Sequences the parent's registered fp16 adder as a per-row accumulator and emits one sum per row.
// Optional per-row nonzero count output enabled by SPMV_ROW_NNZ_CNT_EN.
//
// state | meaning
// IDLE  | waiting for i_start
// ACC   | accepting products of the current row
// DRAIN | adder result of the last beat settling; captured into y_data
// OUT   | row result presented, waiting for y_ready
// DONE  | job complete, o_done pulse
module spmv_row_accum_ctrl
   import spmv_pkg::*;
#(
   parameter int NUM_ROWS = 16,
   parameter int ROW_W    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_start,
   spmv_row_accum_ctrl_if.slave bus,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam logic [ROW_W:0] ROWS_B = (ROW_W+1)'(NUM_ROWS);

   state_e            state_q;
   logic              row_open_q;
   logic [ROW_W-1:0]  row_cnt_q;
   logic              y_valid_q;
   logic [FP16_W-1:0] y_data_q;
   logic [ROW_W-1:0]  y_row_q;
   logic              done_q;

   logic              accept;
   logic              row_more;
   logic [FP16_W-1:0] opnd_a;
   logic [FP16_W-1:0] opnd_b;

   assign accept   = bus.p_valid && (state_q == ACC);
   assign row_more = ({1'b0, row_cnt_q} + 1'b1) < ROWS_B;

   // Outside an accepted beat the adder adds zero to itself, so its register holds the sum.
   always_comb begin
      opnd_a = FP16_ZERO;
      opnd_b = bus.add_result;
      if (accept) begin
         opnd_a = bus.p_empty ? FP16_ZERO : bus.p_data;
         opnd_b = row_open_q ? bus.add_result : FP16_ZERO;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= IDLE;
         row_open_q <= 1'b0;
         row_cnt_q  <= '0;
         y_valid_q  <= 1'b0;
         y_data_q   <= FP16_ZERO;
         y_row_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  state_q    <= ACC;
                  row_cnt_q  <= '0;
                  row_open_q <= 1'b0;
               end
            end
            ACC: begin
               if (accept) begin
                  row_open_q <= !bus.p_last;
                  if (bus.p_last) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               y_data_q  <= bus.add_result;
               y_row_q   <= row_cnt_q;
               y_valid_q <= 1'b1;
               state_q   <= OUT;
            end
            OUT: begin
               if (bus.y_ready) begin
                  y_valid_q <= 1'b0;
                  row_cnt_q <= row_cnt_q + 1'b1;
                  if (row_more) begin
                     state_q <= ACC;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SPMV_ROW_NNZ_CNT_EN
   logic [ROW_W-1:0] nnz_cnt_q;
   logic [ROW_W-1:0] y_nnz_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         nnz_cnt_q <= '0;
         y_nnz_q   <= '0;
      end else if (state_q == IDLE) begin
         nnz_cnt_q <= '0;
      end else if (state_q == DRAIN) begin
         y_nnz_q   <= nnz_cnt_q;
         nnz_cnt_q <= '0;
      end else if (accept && !bus.p_empty && (nnz_cnt_q != '1)) begin
         nnz_cnt_q <= nnz_cnt_q + 1'b1;
      end
   end

   assign bus.y_nnz = y_nnz_q;
`endif

   assign bus.p_ready = (state_q == ACC);
   assign bus.add_a   = opnd_a;
   assign bus.add_b   = opnd_b;
   assign bus.y_valid = y_valid_q;
   assign bus.y_data  = y_data_q;
   assign bus.y_row   = y_row_q;
   assign o_busy      = (state_q != IDLE);
   assign o_done      = done_q;

endmodule
